// File: rtl/keypad_pkg.sv
// Shared key codes, FSM state type and key classification helpers for the
// keypad entry controller.
package keypad_pkg;

    localparam logic [3:0] KEY_ENTER = 4'hA;
    localparam logic [3:0] KEY_BKSP  = 4'hB;
    localparam logic [3:0] KEY_CLR   = 4'hC;
    localparam logic [3:0] KEY_D     = 4'hD;
    localparam logic [3:0] KEY_STAR  = 4'hE;
    localparam logic [3:0] KEY_HASH  = 4'hF;

    typedef enum logic [1:0] {
        S_A    = 2'd0,
        S_B    = 2'd1,
        S_SEND = 2'd2
    } entry_state_t;

    // Decimal digit keys 0..9
    function automatic logic is_digit(input logic [3:0] key);
        return key <= 4'd9;
    endfunction

    // D, * and # carry no meaning for entry and must not touch the timer
    function automatic logic is_ignored(input logic [3:0] key);
        return key >= KEY_D;
    endfunction

endpackage

// File: rtl/keypad_entry_ctrl_buffer.sv
// BCD entry buffer: digit 0 lives in the LSBs, new digits shift in from the
// bottom, backspace shifts out of the bottom. Clear has priority.
module entry_digit_buffer #(
    parameter int MAX_DIGITS = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    push,
    input  logic                    pop,
    input  logic                    clr,
    input  logic [3:0]              digit,
    output logic [4*MAX_DIGITS-1:0] bcd,
    output logic [2:0]              cnt,
    output logic                    full
);

    localparam int BW = 4 * MAX_DIGITS;

    assign full = (cnt == 3'(MAX_DIGITS));

    // Buffer contents and digit count; a push into a full buffer is dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcd <= '0;
            cnt <= '0;
        end else if (clr) begin
            bcd <= '0;
            cnt <= '0;
        end else if (push && !full) begin
            bcd <= (bcd << 4) | BW'(digit);
            cnt <= cnt + 3'd1;
        end else if (pop && cnt != 3'd0) begin
            bcd <= bcd >> 4;
            cnt <= cnt - 3'd1;
        end
    end

endmodule

// File: rtl/keypad_entry_ctrl.sv
// Keypad entry sequencer: collects operand A then operand B as decimal
// digits, converts to binary on commit and hands both operands downstream
// over valid/ready. Stale partial entries are aborted after an idle timeout.
module keypad_entry_ctrl
    import keypad_pkg::*;
#(
    parameter int MAX_DIGITS     = 3,
    parameter int BIN_W          = 10,
    parameter int TIMEOUT_CYCLES = 27_000_000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [3:0]              key_value,
    input  logic                    key_valid,
    output logic [BIN_W-1:0]        op_a,
    output logic [BIN_W-1:0]        op_b,
    output logic                    op_valid,
    input  logic                    op_ready,
    output logic [4*MAX_DIGITS-1:0] disp_bcd,
    output logic [2:0]              disp_cnt,
    output logic                    entering_b,
    output logic                    overflow,
    output logic                    timeout
);

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

    entry_state_t            state;
    logic [TW-1:0]           timer;
    logic [4*MAX_DIGITS-1:0] buf_bcd;
    logic [2:0]              buf_cnt;
    logic                    buf_full;
    logic [BIN_W-1:0]        bin_val;

    logic key_act, kv_digit, kv_enter, kv_bksp, kv_clr;
    logic counting, expire;
    logic buf_push, buf_pop, buf_clr;

    // Key decode: keys are dropped entirely while the handshake is pending
    always_comb begin
        key_act  = key_valid && (state != S_SEND) && !is_ignored(key_value);
        kv_digit = key_act && is_digit(key_value);
        kv_enter = key_act && (key_value == KEY_ENTER);
        kv_bksp  = key_act && (key_value == KEY_BKSP);
        kv_clr   = key_act && (key_value == KEY_CLR);
        counting = ((state == S_A) && (buf_cnt != 3'd0)) || (state == S_B);
        // A key on the expiring cycle takes precedence over the abort
        expire   = counting && (timer == T_LAST) && !key_act;
        buf_push = kv_digit;
        buf_pop  = kv_bksp;
        buf_clr  = kv_enter || kv_clr || expire;
    end

    entry_digit_buffer #(
        .MAX_DIGITS (MAX_DIGITS)
    ) u_buf (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (buf_push),
        .pop   (buf_pop),
        .clr   (buf_clr),
        .digit (key_value),
        .bcd   (buf_bcd),
        .cnt   (buf_cnt),
        .full  (buf_full)
    );

    // Horner evaluation of the BCD buffer, most significant digit first
    always_comb begin
        bin_val = '0;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            bin_val = BIN_W'(bin_val * BIN_W'(10))
                    + BIN_W'(buf_bcd[4*(MAX_DIGITS-1-i) +: 4]);
        end
    end

    // Entry FSM with operand registers, handshake, pulses and idle timer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_A;
            op_a     <= '0;
            op_b     <= '0;
            op_valid <= 1'b0;
            overflow <= 1'b0;
            timeout  <= 1'b0;
            timer    <= '0;
        end else begin
            overflow <= kv_digit && buf_full;
            timeout  <= expire;

            if (key_act)
                timer <= '0;
            else if (counting && !expire)
                timer <= timer + TW'(1);
            else
                timer <= '0;

            case (state)
                S_A: begin
                    if (kv_enter) begin
                        op_a  <= bin_val;
                        state <= S_B;
                    end
                end
                S_B: begin
                    if (kv_enter) begin
                        op_b     <= bin_val;
                        op_valid <= 1'b1;
                        state    <= S_SEND;
                    end else if (kv_clr && buf_cnt == 3'd0) begin
                        state <= S_A;
                    end else if (expire) begin
                        state <= S_A;
                    end
                end
                S_SEND: begin
                    if (op_ready) begin
                        op_valid <= 1'b0;
                        state    <= S_A;
                    end
                end
                default: state <= S_A;
            endcase
        end
    end

    assign disp_bcd   = buf_bcd;
    assign disp_cnt   = buf_cnt;
    assign entering_b = (state == S_B);

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Bench for keypad_entry_ctrl: directed sequences plus random keys, all
// checked against a value-level model of the entry rules.
module tb_keypad_entry_ctrl;

    localparam int MAXD  = 3;
    localparam int BW    = 10;
    localparam int TOUT  = 16;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [3:0]      key_value = 4'd0;
    logic            key_valid = 1'b0;
    logic            op_ready = 1'b0;
    logic [BW-1:0]   op_a, op_b;
    logic            op_valid;
    logic [4*MAXD-1:0] disp_bcd;
    logic [2:0]      disp_cnt;
    logic            entering_b, overflow, timeout;

    int checks = 0;
    int errors = 0;

    // model state: mode 0=entering A, 1=entering B, 2=waiting for accept
    int     m_mode, m_val, m_cnt, m_a, m_b;
    bit     m_valid, m_ovf, m_to;
    longint m_n, m_deadline;

    always #5 clk = ~clk;

    keypad_entry_ctrl #(
        .MAX_DIGITS     (MAXD),
        .BIN_W          (BW),
        .TIMEOUT_CYCLES (TOUT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_value  (key_value),
        .key_valid  (key_valid),
        .op_a       (op_a),
        .op_b       (op_b),
        .op_valid   (op_valid),
        .op_ready   (op_ready),
        .disp_bcd   (disp_bcd),
        .disp_cnt   (disp_cnt),
        .entering_b (entering_b),
        .overflow   (overflow),
        .timeout    (timeout)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [4*MAXD-1:0] to_bcd(input int v);
        logic [4*MAXD-1:0] r;
        int p;
        r = '0;
        p = 1;
        for (int i = 0; i < MAXD; i++) begin
            r[4*i +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_val = 0; m_cnt = 0; m_a = 0; m_b = 0;
        m_valid = 0; m_ovf = 0; m_to = 0; m_deadline = -1;
    endtask

    // Advance the model by one clock edge given the inputs about to be sampled
    task automatic model_edge(input bit v, input int k, input bit r);
        bit key;
        m_n++;
        m_ovf = 0;
        m_to  = 0;
        key = v && (m_mode != 2) && (k < 13);
        if (m_mode == 2) begin
            if (r) begin
                m_valid = 0;
                m_mode  = 0;
            end
        end else if (key) begin
            if (k <= 9) begin
                if (m_cnt < MAXD) begin
                    m_val = m_val * 10 + k;
                    m_cnt++;
                end else m_ovf = 1;
            end else if (k == 11) begin
                if (m_cnt > 0) begin
                    m_val = m_val / 10;
                    m_cnt--;
                end
            end else if (k == 12) begin
                if (m_cnt > 0) begin
                    m_val = 0; m_cnt = 0;
                end else if (m_mode == 1) m_mode = 0;
            end else begin
                if (m_mode == 0) begin
                    m_a = m_val; m_mode = 1;
                end else begin
                    m_b = m_val; m_valid = 1; m_mode = 2;
                end
                m_val = 0; m_cnt = 0;
            end
            // a partial entry (or any B entry) aborts TOUT edges after its last key
            m_deadline = (m_mode == 1 || (m_mode == 0 && m_cnt > 0)) ? m_n + TOUT : -1;
        end else if (m_deadline == m_n) begin
            m_val = 0; m_cnt = 0; m_mode = 0; m_to = 1; m_deadline = -1;
        end
    endtask

    task automatic check_all();
        chk("op_a",       32'(op_a),       32'(m_a));
        chk("op_b",       32'(op_b),       32'(m_b));
        chk("op_valid",   32'(op_valid),   32'(m_valid));
        chk("disp_bcd",   32'(disp_bcd),   32'(to_bcd(m_val)));
        chk("disp_cnt",   32'(disp_cnt),   32'(m_cnt));
        chk("entering_b", 32'(entering_b), 32'(m_mode == 1));
        chk("overflow",   32'(overflow),   32'(m_ovf));
        chk("timeout",    32'(timeout),    32'(m_to));
    endtask

    task automatic step(input bit v, input int k, input bit r);
        key_valid = v;
        key_value = 4'(k);
        op_ready  = r;
        model_edge(v, k, r);
        @(posedge clk);
        #1;
        key_valid = 1'b0;
        op_ready  = 1'b0;
        check_all();
    endtask

    task automatic key(input int k);
        step(1'b1, k, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 0, 1'b0);
    endtask

    initial begin
        model_reset();
        m_n = 0;
        #12;
        check_all();
        #10 rst_n = 1'b1;

        // two operands, then held valid, then accept
        key(1); key(2); key(3); key(10);
        chk("b_after_enter", 32'(entering_b), 32'd1);
        key(4); key(5); key(10);
        chk("valid_rise", 32'(op_valid), 32'd1);
        chk("op_a_123", 32'(op_a), 32'd123);
        chk("op_b_45", 32'(op_b), 32'd45);
        idle(10);
        chk("valid_hold", 32'(op_valid), 32'd1);
        step(1'b0, 0, 1'b1);
        chk("valid_drop", 32'(op_valid), 32'd0);

        // overflow, backspace
        key(9); key(8); key(7);
        chk("bcd_987", 32'(disp_bcd), 32'h987);
        key(6);
        chk("ovf_pulse", 32'(overflow), 32'd1);
        chk("bcd_keep", 32'(disp_bcd), 32'h987);
        key(11); key(11);
        chk("bcd_009", 32'(disp_bcd), 32'h009);
        key(10);
        chk("op_a_9", 32'(op_a), 32'd9);

        // clear behaviour in B
        key(12);
        chk("cancel_b", 32'(entering_b), 32'd0);
        chk("op_a_kept", 32'(op_a), 32'd9);
        key(10); key(1); key(2); key(12);
        chk("clr_cnt", 32'(disp_cnt), 32'd0);
        chk("clr_stay_b", 32'(entering_b), 32'd1);
        key(12);

        // timeout, with ignored keys inside the window
        key(5);
        for (int j = 1; j <= TOUT; j++) begin
            if (j == 4) step(1'b1, 13, 1'b0);
            else if (j == 8) step(1'b1, 14, 1'b0);
            else if (j == 12) step(1'b1, 15, 1'b0);
            else step(1'b0, 0, 1'b0);
        end
        chk("timeout_pulse", 32'(timeout), 32'd1);
        chk("timeout_cnt", 32'(disp_cnt), 32'd0);

        // empty operands, key coincident with accept, async reset
        key(10); key(10);
        chk("empty_valid", 32'(op_valid), 32'd1);
        chk("empty_a", 32'(op_a), 32'd0);
        chk("empty_b", 32'(op_b), 32'd0);
        step(1'b1, 7, 1'b1);
        chk("drop_cnt", 32'(disp_cnt), 32'd0);
        chk("drop_valid", 32'(op_valid), 32'd0);
        key(10); key(10);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(op_valid), 32'd0);
        model_reset();
        check_all();
        #3 rst_n = 1'b1;

        // random keys, random ready, with occasional long idle stretches
        for (int i = 0; i < 600; i++) begin
            int k;
            bit v, r;
            v = ($urandom_range(0, 3) == 0);
            k = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 9) : $urandom_range(10, 15);
            r = ($urandom_range(0, 2) == 0);
            step(v, k, r);
            if (i % 100 == 50) idle(20);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
